// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the two-client (icache/dcache) memory arbiter:
// line/address widths, assumed memory latency and FSM/client encodings.
package memory_arbiter_pkg;

  localparam int ADDR_W              = 20;
  localparam int LINE_W              = 128;
  localparam int MEMORY_DELAY_CYCLES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    CL_IC = 1'b0,
    CL_DC = 1'b1
  } client_e;

endpackage

// File: rtl/memory_arbiter_grant.sv
// Grant select between instruction and data cache requests, plus the
// round-robin pointer when MEMORY_ARBITER_ROUND_ROBIN_EN is defined.
module memory_arbiter_grant
  import memory_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    ic_req,
  input  logic    dc_req,
  input  logic    grant_en,
  output logic    grant_valid,
  output client_e grant_client
);

  assign grant_valid = grant_en && (ic_req || dc_req);

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  // prefer_ic is set after a data grant so the next conflict favours the icache
  logic prefer_ic;

  always_comb begin
    grant_client = CL_IC;
    if (ic_req && dc_req)
      grant_client = prefer_ic ? CL_IC : CL_DC;
    else if (dc_req)
      grant_client = CL_DC;
  end

  always_ff @(posedge clk) begin
    if (reset)
      prefer_ic <= 1'b0;
    else if (grant_valid)
      prefer_ic <= (grant_client == CL_DC);
  end
`else
  logic unused_clk_reset;
  assign unused_clk_reset = clk ^ reset;

  always_comb begin
    grant_client = CL_IC;
    if (dc_req)
      grant_client = CL_DC;
  end
`endif

endmodule

// File: rtl/memory_arbiter.sv
// Serialises icache line reads and dcache fills/write-backs onto one memory port.
// Optional round-robin conflict resolution: MEMORY_ARBITER_ROUND_ROBIN_EN.
module memory_arbiter
  import memory_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  input  logic              ic_abort,
  output logic              ic_ready,
  output logic [LINE_W-1:0] ic_data,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wr_data,
  output logic              dc_ready,
  output logic [LINE_W-1:0] dc_rd_data,
  output logic              mem_requested,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wr_data,
  output logic              mem_reset_req,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_rd_data,
  input  logic              is_loading_memory_into_core
);

  arb_state_e        state, state_nxt;
  client_e           lat_client;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [LINE_W-1:0] lat_wr_data;

  logic    grant_en;
  logic    grant_valid;
  client_e grant_client;
  logic    abort_hit;
  logic    capture;

  memory_arbiter_grant u_grant (
    .clk          (clk),
    .reset        (reset),
    .ic_req       (ic_req),
    .dc_req       (dc_req),
    .grant_en     (grant_en),
    .grant_valid  (grant_valid),
    .grant_client (grant_client)
  );

  // Only an instruction transaction can be flushed; data writes/fills run to completion
  assign abort_hit = ic_abort && (lat_client == CL_IC);

  always_comb begin
    state_nxt     = state;
    grant_en      = 1'b0;
    mem_requested = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wr_data   = '0;
    mem_reset_req = 1'b0;
    ic_ready      = 1'b0;
    dc_ready      = 1'b0;
    capture       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        grant_en = !is_loading_memory_into_core;
        if (grant_valid)
          state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        mem_we      = lat_we;
        mem_addr    = lat_addr;
        mem_wr_data = lat_wr_data;
        if (abort_hit) begin
          mem_reset_req = 1'b1;
          state_nxt     = ST_IDLE;
        end else if (mem_ready) begin
          mem_requested = 1'b1;
          state_nxt     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        mem_we      = lat_we;
        mem_addr    = lat_addr;
        mem_wr_data = lat_wr_data;
        if (abort_hit) begin
          mem_reset_req = 1'b1;
          state_nxt     = ST_IDLE;
        end else if (mem_ready) begin
          capture   = !lat_we;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        ic_ready  = (lat_client == CL_IC);
        dc_ready  = (lat_client == CL_DC);
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Grant stage: latch the winning client's command for the whole transaction
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_client  <= CL_IC;
      lat_addr    <= '0;
      lat_we      <= 1'b0;
      lat_wr_data <= '0;
    end else if (state == ST_IDLE && grant_valid) begin
      lat_client <= grant_client;
      if (grant_client == CL_DC) begin
        lat_addr    <= dc_addr;
        lat_we      <= dc_we;
        lat_wr_data <= dc_wr_data;
      end else begin
        lat_addr    <= ic_addr;
        lat_we      <= 1'b0;
        lat_wr_data <= '0;
      end
    end
  end

  // Response stage: read lines are held until the same client's next read
  always_ff @(posedge clk) begin
    if (reset) begin
      ic_data    <= '0;
      dc_rd_data <= '0;
    end else if (capture) begin
      if (lat_client == CL_IC)
        ic_data <= mem_rd_data;
      else
        dc_rd_data <= mem_rd_data;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomised scoreboard bench for memory_arbiter with a latency-D memory model.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int D = MEMORY_DELAY_CYCLES;

  logic              clk, reset;
  logic              ic_req, ic_abort, ic_ready;
  logic [ADDR_W-1:0] ic_addr;
  logic [LINE_W-1:0] ic_data;
  logic              dc_req, dc_we, dc_ready;
  logic [ADDR_W-1:0] dc_addr;
  logic [LINE_W-1:0] dc_wr_data, dc_rd_data;
  logic              mem_requested, mem_we, mem_reset_req, mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wr_data, mem_rd_data;
  logic              is_loading_memory_into_core;

  memory_arbiter dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_abort(ic_abort),
    .ic_ready(ic_ready), .ic_data(ic_data),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wr_data(dc_wr_data),
    .dc_ready(dc_ready), .dc_rd_data(dc_rd_data),
    .mem_requested(mem_requested), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_reset_req(mem_reset_req),
    .mem_ready(mem_ready), .mem_rd_data(mem_rd_data),
    .is_loading_memory_into_core(is_loading_memory_into_core)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [LINE_W-1:0] init_line(int a);
    if (a == 16) return {16{8'hA5}};
    return {4{32'hC0DE0000 | a}};
  endfunction

  // Memory device: busy for D cycles after each request, cancellable.
  logic [LINE_W-1:0] dev_mem     [0:255];
  bit                dev_written [0:255];
  bit                dev_cleared;
  int                dev_cnt;

  assign mem_ready   = (dev_cnt == 0);
  assign mem_rd_data = dev_written[mem_addr[7:0]] ? dev_mem[mem_addr[7:0]]
                                                  : init_line(int'(mem_addr[7:0]));

  always @(posedge clk) begin
    if (!dev_cleared) begin
      for (int i = 0; i < 256; i++) dev_written[i] <= 1'b0;
      dev_cleared <= 1'b1;
    end
    if (reset || mem_reset_req)
      dev_cnt <= 0;
    else if (mem_requested) begin
      dev_cnt <= D;
      if (mem_we) begin
        dev_mem[mem_addr[7:0]]     <= mem_wr_data;
        dev_written[mem_addr[7:0]] <= 1'b1;
      end
    end else if (dev_cnt > 0)
      dev_cnt <= dev_cnt - 1;
  end

  // Scoreboard and reference model
  typedef struct { bit is_dc; logic [LINE_W-1:0] data; } resp_t;
  typedef struct { bit we; logic [ADDR_W-1:0] addr; logic [LINE_W-1:0] wdata; } memop_t;
  resp_t  exp_resp[$];
  memop_t exp_op[$];

  int checks = 0;
  int errors = 0;
  int rst_pulses = 0;

  logic [LINE_W-1:0] ref_mem     [0:255];
  bit                ref_written [0:255];
  bit                prefer_ic;
  logic [LINE_W-1:0] last_ic, last_dc;

  function automatic void check(string name, logic [LINE_W-1:0] act, logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [LINE_W-1:0] ref_read(logic [ADDR_W-1:0] a);
    return ref_written[a[7:0]] ? ref_mem[a[7:0]] : init_line(int'(a[7:0]));
  endfunction

  function automatic void model_serve(bit is_dc, bit we, logic [ADDR_W-1:0] a, logic [LINE_W-1:0] wd);
    prefer_ic = is_dc;
    if (!is_dc) begin
      exp_op.push_back('{we: 1'b0, addr: a, wdata: '0});
      last_ic = ref_read(a);
      exp_resp.push_back('{is_dc: 1'b0, data: last_ic});
    end else if (we) begin
      exp_op.push_back('{we: 1'b1, addr: a, wdata: wd});
      ref_mem[a[7:0]]     = wd;
      ref_written[a[7:0]] = 1'b1;
      exp_resp.push_back('{is_dc: 1'b1, data: last_dc});
    end else begin
      exp_op.push_back('{we: 1'b0, addr: a, wdata: '0});
      last_dc = ref_read(a);
      exp_resp.push_back('{is_dc: 1'b1, data: last_dc});
    end
  endfunction

  // Monitor: pops expectations whenever the DUT responds or touches memory
  resp_t  mon_r;
  memop_t mon_op;
  logic   prev_mreq;

  always @(negedge clk) begin
    if (reset) begin
      prev_mreq <= 1'b0;
    end else begin
      if (mem_reset_req) rst_pulses <= rst_pulses + 1;
      if (ic_ready || dc_ready) begin
        check("resp_mem_outputs_idle", {mem_requested, mem_we, mem_addr, mem_wr_data}, '0);
        check("single_ready", {ic_ready, dc_ready} == 2'b11, 0);
        if (exp_resp.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ready: got ic=%0d dc=%0d expected none", ic_ready, dc_ready);
        end else begin
          mon_r = exp_resp.pop_front();
          check("ready_client", dc_ready, mon_r.is_dc);
          if (mon_r.is_dc) check("dc_rd_data", dc_rd_data, mon_r.data);
          else             check("ic_data", ic_data, mon_r.data);
        end
      end
      if (mem_requested) begin
        check("mem_requested_one_cycle", prev_mreq, 0);
        if (exp_op.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_mem_request: got addr %h expected none", mem_addr);
        end else begin
          mon_op = exp_op.pop_front();
          check("mem_addr", mem_addr, mon_op.addr);
          check("mem_we", mem_we, mon_op.we);
          if (mon_op.we) check("mem_wr_data", mem_wr_data, mon_op.wdata);
        end
      end
      prev_mreq <= mem_requested;
    end
  end

  task automatic start_txn(bit ic_on, bit dc_on, logic [ADDR_W-1:0] ia,
                           bit we, logic [ADDR_W-1:0] da, logic [LINE_W-1:0] wd);
    bit dc_first;
    @(negedge clk);
    if (ic_on && dc_on) begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
      dc_first = !prefer_ic;
`else
      dc_first = 1'b1;
`endif
      if (dc_first) begin
        model_serve(1'b1, we, da, wd);
        model_serve(1'b0, 1'b0, ia, '0);
      end else begin
        model_serve(1'b0, 1'b0, ia, '0);
        model_serve(1'b1, we, da, wd);
      end
    end else if (ic_on) model_serve(1'b0, 1'b0, ia, '0);
    else if (dc_on)     model_serve(1'b1, we, da, wd);
    ic_req = ic_on; ic_addr = ia;
    dc_req = dc_on; dc_we = we; dc_addr = da; dc_wr_data = wd;
  endtask

  task automatic wait_done(bit chk_lat);
    int n = 0;
    while ((ic_req || dc_req) && n < 200) begin
      @(negedge clk);
      n++;
      if (chk_lat && (ic_ready || dc_ready)) check("latency", n, D + 3);
      if (ic_ready) ic_req = 1'b0;
      if (dc_ready) dc_req = 1'b0;
    end
    if (ic_req || dc_req) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got no ready after %0d cycles expected ready", n);
      ic_req = 1'b0; dc_req = 1'b0;
    end
  endtask

  task automatic check_all_zero(string name);
    check({name, "_ctrl"}, {ic_ready, dc_ready, mem_requested, mem_we, mem_reset_req, mem_addr}, '0);
    check({name, "_ic_data"}, ic_data, '0);
    check({name, "_dc_rd_data"}, dc_rd_data, '0);
    check({name, "_mem_wr_data"}, mem_wr_data, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    logic [LINE_W-1:0] saved;
    ic_req = 0; ic_addr = '0; ic_abort = 0;
    dc_req = 0; dc_we = 0; dc_addr = '0; dc_wr_data = '0;
    is_loading_memory_into_core = 0;
    reset = 1;
    prefer_ic = 0; last_ic = '0; last_dc = '0;
    for (int i = 0; i < 256; i++) ref_written[i] = 1'b0;
    repeat (4) @(negedge clk);
    check_all_zero("reset");
    reset = 0;

    // Single icache read of the A5 line
    start_txn(1, 0, 20'h00010, 0, '0, '0);
    wait_done(1);
    check("ic_data_A5", ic_data, {16{8'hA5}});

    // Single dcache write-back; read data register must not move
    start_txn(0, 1, '0, 1, 20'h00020, 128'h1234);
    wait_done(1);
    check("dc_rd_data_after_write", dc_rd_data, '0);

    // Two conflicts in a row
    start_txn(1, 1, 20'h00005, 0, 20'h00020, '0);
    wait_done(0);
    start_txn(1, 1, 20'h00006, 0, 20'h00007, '0);
    wait_done(0);

    // Random traffic
    for (int it = 0; it < 40; it++) begin
      int kind;
      kind = $urandom_range(0, 2);
      start_txn(kind != 1, kind != 0, 20'($urandom_range(0, 255)), 1'($urandom),
                20'($urandom_range(0, 255)), {$urandom, $urandom, $urandom, $urandom});
      wait_done(kind != 2);
    end

    // Abort in the second WAIT cycle
    @(negedge clk);
    p0 = rst_pulses;
    saved = last_ic;
    prefer_ic = 1'b0;
    exp_op.push_back('{we: 1'b0, addr: 20'h00007, wdata: '0});
    ic_req = 1; ic_addr = 20'h00007;
    repeat (3) @(posedge clk);
    #1 ic_abort = 1; ic_req = 0;
    @(negedge clk);
    check("abort_mem_reset_req", mem_reset_req, 1);
    @(posedge clk);
    #1 ic_abort = 0;
    repeat (D + 6) @(negedge clk);
    check("abort_reset_pulses", rst_pulses - p0, 1);
    check("abort_ic_data_kept", ic_data, saved);

    // Boot loader blocks new grants
    is_loading_memory_into_core = 1;
    start_txn(0, 1, '0, 0, 20'h00010, '0);
    repeat (8) begin
      @(negedge clk);
      check("loading_blocks", {mem_requested, dc_ready}, '0);
    end
    is_loading_memory_into_core = 0;
    wait_done(0);

    // Reset in WAIT abandons the transaction
    start_txn(1, 0, 20'h00009, 0, '0, '0);
    repeat (2) @(negedge clk);
    reset = 1; ic_req = 0;
    @(negedge clk);
    check_all_zero("midreset");
    exp_resp.delete();
    prefer_ic = 0; last_ic = '0; last_dc = '0;
    reset = 0;
    start_txn(1, 0, 20'h00009, 0, '0, '0);
    wait_done(1);

    repeat (3) @(negedge clk);
    check("queues_empty", exp_resp.size() + exp_op.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have one clock and one reset: the clock port is clk, and reset is synchronous and active-high (reset).
REQ-002 SHALL have these ports, listed as name  direction  width  meaning:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous active-high reset
- ic_req  in  1  instruction-cache line read request
- ic_addr  in  20  instruction line word address
- ic_abort  in  1  fetch flush; cancels a pending instruction read
- ic_ready  out  1  one-cycle response pulse
- ic_data  out  128  returned instruction line
- dc_req  in  1  data-cache request
- dc_we  in  1  1 = line write-back, 0 = line fill
- dc_addr  in  20  data line word address
- dc_wr_data  in  128  write-back line
- dc_ready  out  1  one-cycle response pulse
- dc_rd_data  out  128  returned data line
- mem_requested  out  1  request to memory
- mem_we  out  1  write enable to memory
- mem_addr  out  20  address to memory
- mem_wr_data  out  128  write line to memory
- mem_reset_req  out  1  cancel an in-flight memory operation
- mem_ready  in  1  memory idle or done
- mem_rd_data  in  128  memory read line; combinational on mem_addr
- is_loading_memory_into_core  in  1  boot loader owns memory

Function
REQ-003 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
REQ-004 IDLE: when a client request is present and is_loading_memory_into_core=0, SHALL grant one client and latch its addr, we and wr_data into internal registers, then go to ISSUE. With no request, SHALL stay in IDLE.
REQ-005 ISSUE: SHALL assert mem_requested for exactly one cycle when mem_ready=1, then go to WAIT. While mem_ready=0, SHALL stay in ISSUE with mem_requested=0.
REQ-006 WAIT: mem_requested=0. When mem_ready=1, SHALL capture mem_rd_data into the granted client's data register (reads only) and go to RESP.
REQ-007 mem_addr, mem_we and mem_wr_data SHALL be driven from the latched registers and held stable from ISSUE through WAIT. In IDLE and RESP they SHALL be 0.
REQ-008 RESP: SHALL pulse the granted client's ready for one cycle, and ignore ic_req/dc_req in that cycle.
REQ-009 ic_data and dc_rd_data SHALL hold their value until that client's next read response.
REQ-010 Latency: a request sampled in IDLE with memory idle SHALL produce ready exactly MEMORY_DELAY_CYCLES+3 cycles later.
REQ-011 On simultaneous ic_req and dc_req, the grant SHALL follow REQ-016.
REQ-012 If ic_abort=1 while an instruction read is in ISSUE or WAIT:
- pulse mem_reset_req for one cycle
- return to IDLE
- do not pulse ic_ready
- leave ic_data unchanged
ic_abort SHALL be ignored in every other case, including a data transaction.
REQ-013 Data writes SHALL be non-abortable. dc_ready SHALL be pulsed on write completion, and dc_rd_data SHALL stay unchanged on a write.
REQ-014 is_loading_memory_into_core=1 SHALL block new grants. A transaction already in flight SHALL still complete.

Reset
REQ-015 Reset SHALL put the FSM in IDLE and clear all of these to 0:
- ic_ready, dc_ready
- ic_data, dc_rd_data
- mem_requested, mem_we, mem_addr, mem_wr_data, mem_reset_req
- the latched registers and the priority pointer
Reset mid-transaction SHALL abandon the transaction with no ready pulse. mem_reset_req SHALL NOT be asserted by reset, because the memory resets itself.

Configuration
REQ-016 With MEMORY_ARBITER_ROUND_ROBIN_EN defined, conflicting requests SHALL be granted to the client not granted last; the pointer updates on every grant, and the first conflict after reset goes to the data cache. Without the macro, the data cache SHALL always win conflicts.

Structure
REQ-017 The shared definitions file SHALL hold:
- the FSM state encodings
- address width 20
- line width 128
- MEMORY_DELAY_CYCLES
REQ-018 The grant selection SHALL be one sub-module, memory_arbiter_grant: a combinational priority/round-robin select plus the pointer register.

Verification
REQ-019 Single-client cases:
- ic_req, ic_addr=0x00010, memory returning 0xA5..A5 -> ic_ready pulses at +D+3 and ic_data=0xA5..A5.
- dc_req, dc_we=1, dc_addr=0x00020, dc_wr_data=0x1234 -> one-cycle mem_requested with mem_we=1, mem_addr=0x00020; then dc_ready; dc_rd_data unchanged.
REQ-020 Simultaneous ic_req+dc_req twice in a row:
- fixed priority -> dc, dc
- round-robin -> dc then ic
REQ-021 Abort and blocking cases:
- ic_abort asserted in the 2nd WAIT cycle -> mem_reset_req pulses once, FSM returns to IDLE, no ic_ready.
- is_loading_memory_into_core=1 with dc_req -> no mem_requested until it drops.
REQ-022 reset asserted in WAIT -> next cycle all outputs are 0 and the FSM is in IDLE; a new ic_req then completes normally.
